// File: rtl/bp_btb_multi.sv
// Fully-associative MRU-ordered branch target buffer producing a chain of predicted fetch addresses.
// Optional 2-bit confidence hysteresis is enabled by defining BTB_CONFIDENCE_EN.
module bp_btb_multi #(
  parameter int BTB_SIZE      = 8,
  parameter int ABITS         = 64,   // RISCV_ARCH
  parameter int PREDICT_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_nrst,
  input  logic                           i_flush_pipeline,
  input  logic                           i_we,
  input  logic [ABITS-1:0]               i_we_pc,
  input  logic [ABITS-1:0]               i_we_npc,
  input  logic                           i_we_exec,
  input  logic [ABITS-1:0]               i_bp_pc,
  output logic [PREDICT_DEPTH*ABITS-1:0] o_bp_npc,
  output logic [PREDICT_DEPTH-1:0]       o_bp_exec
);

  localparam int IW = (BTB_SIZE > 1) ? $clog2(BTB_SIZE) : 1;

  logic [BTB_SIZE-1:0] valid_q;
  logic [ABITS-1:0]    pc_q  [BTB_SIZE];
  logic [ABITS-1:0]    npc_q [BTB_SIZE];
  logic [BTB_SIZE-1:0] exec_q;
`ifdef BTB_CONFIDENCE_EN
  logic [1:0]          cnt_q [BTB_SIZE];
  logic [1:0]          upd_cnt;
`endif

  logic [BTB_SIZE-1:0] usable;
  logic [ABITS-1:0]    cur_pc;
  logic [ABITS-1:0]    nxt_pc;
  logic                nxt_exec;

  logic                hit;
  logic [IW-1:0]       hit_idx;
  logic [BTB_SIZE-1:0] shift_en;
  logic                keep;
  logic                write_en;
  logic [ABITS-1:0]    upd_npc;
  logic                upd_exec;

  always_comb begin
    usable = '0;
    for (int i = 0; i < BTB_SIZE; i++) begin
`ifdef BTB_CONFIDENCE_EN
      usable[i] = valid_q[i] & cnt_q[i][1];
`else
      usable[i] = valid_q[i];
`endif
    end
  end

  // Each slot looks up the previous slot; a miss falls through to sequential fetch.
  always_comb begin
    o_bp_npc  = '0;
    o_bp_exec = '0;
    nxt_pc    = '0;
    nxt_exec  = 1'b0;
    cur_pc    = i_bp_pc;
    o_bp_npc[0 +: ABITS] = i_bp_pc;
    for (int n = 1; n < PREDICT_DEPTH; n++) begin
      nxt_pc   = cur_pc + ABITS'(4);
      nxt_exec = 1'b0;
      for (int i = BTB_SIZE - 1; i >= 0; i--) begin
        if (usable[i] && (pc_q[i] == cur_pc)) begin
          nxt_pc   = npc_q[i];
          nxt_exec = exec_q[i];
        end
      end
      o_bp_npc[n*ABITS +: ABITS] = nxt_pc;
      o_bp_exec[n]               = nxt_exec;
      cur_pc                     = nxt_pc;
    end
  end

  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    keep     = 1'b0;
    upd_npc  = i_we_npc;
    upd_exec = i_we_exec;
    shift_en = '0;
`ifdef BTB_CONFIDENCE_EN
    upd_cnt  = 2'd2;
`endif
    for (int i = BTB_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && (pc_q[i] == i_we_pc)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    if (hit) begin
      if (exec_q[hit_idx] && !i_we_exec) begin
        keep = 1'b1;
      end else if (npc_q[hit_idx] == i_we_npc) begin
        upd_exec = exec_q[hit_idx] | i_we_exec;
`ifdef BTB_CONFIDENCE_EN
        upd_cnt  = (cnt_q[hit_idx] == 2'd3) ? 2'd3 : cnt_q[hit_idx] + 2'd1;
`endif
      end
`ifdef BTB_CONFIDENCE_EN
      else if (i_we_exec && (cnt_q[hit_idx] == 2'd3)) begin
        // A confident exec target survives one contradicting resolution.
        upd_npc  = npc_q[hit_idx];
        upd_exec = 1'b1;
      end
`endif
    end
    // Miss shifts the whole table; a hit at k shifts only entries 0..k-1.
    for (int i = 1; i < BTB_SIZE; i++) begin
      shift_en[i] = !hit || (IW'(i) <= hit_idx);
    end
    write_en = i_we && !keep;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      valid_q <= '0;
      exec_q  <= '0;
      for (int i = 0; i < BTB_SIZE; i++) begin
        pc_q[i]  <= '0;
        npc_q[i] <= '0;
`ifdef BTB_CONFIDENCE_EN
        cnt_q[i] <= 2'd0;
`endif
      end
    end else if (i_flush_pipeline) begin
      valid_q <= '0;
    end else if (write_en) begin
      valid_q[0] <= 1'b1;
      pc_q[0]    <= i_we_pc;
      npc_q[0]   <= upd_npc;
      exec_q[0]  <= upd_exec;
`ifdef BTB_CONFIDENCE_EN
      cnt_q[0]   <= upd_cnt;
`endif
      for (int i = 1; i < BTB_SIZE; i++) begin
        if (shift_en[i]) begin
          valid_q[i] <= valid_q[i-1];
          pc_q[i]    <= pc_q[i-1];
          npc_q[i]   <= npc_q[i-1];
          exec_q[i]  <= exec_q[i-1];
`ifdef BTB_CONFIDENCE_EN
          cnt_q[i]   <= cnt_q[i-1];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_btb_multi.sv
// Bench for bp_btb_multi: directed vector table, MRU eviction sequence, reset-mid-update,
// and randomized traffic against a queue-based reference model.
module tb_bp_btb_multi;

  localparam int AB = 64;
  localparam int D  = 4;
  localparam int N  = 8;
  localparam int W  = D*AB + D;
`ifdef BTB_CONFIDENCE_EN
  localparam bit CONF = 1'b1;
`else
  localparam bit CONF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            i_nrst = 1'b0;
  logic            i_flush_pipeline = 1'b0;
  logic            i_we = 1'b0;
  logic [AB-1:0]   i_we_pc = '0;
  logic [AB-1:0]   i_we_npc = '0;
  logic            i_we_exec = 1'b0;
  logic [AB-1:0]   i_bp_pc = '0;
  logic [D*AB-1:0] o_bp_npc;
  logic [D-1:0]    o_bp_exec;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  bp_btb_multi #(.BTB_SIZE(N), .ABITS(AB), .PREDICT_DEPTH(D)) dut (
    .i_clk(clk), .i_nrst(i_nrst), .i_flush_pipeline(i_flush_pipeline),
    .i_we(i_we), .i_we_pc(i_we_pc), .i_we_npc(i_we_npc), .i_we_exec(i_we_exec),
    .i_bp_pc(i_bp_pc), .o_bp_npc(o_bp_npc), .o_bp_exec(o_bp_exec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          flush;
    logic          we;
    logic [AB-1:0] we_pc;
    logic [AB-1:0] we_npc;
    logic          we_exec;
    logic [AB-1:0] bp_pc;
    logic [W-1:0]  exp;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    logic [AB-1:0] pc;
    logic [AB-1:0] npc;
    logic          ex;
    int            cnt;
  } ent_t;
  ent_t mq[$];

  function automatic logic [W-1:0] chain(input logic [AB-1:0] s0, input logic [AB-1:0] s1,
                                         input logic [AB-1:0] s2, input logic [AB-1:0] s3,
                                         input logic [D-1:0] ex);
    return {s3, s2, s1, s0, ex};
  endfunction

  function automatic vec_t mk(input logic fl, input logic we, input logic [AB-1:0] wpc,
                              input logic [AB-1:0] wnpc, input logic wex,
                              input logic [AB-1:0] bp, input logic [W-1:0] e);
    vec_t v;
    v.flush = fl; v.we = we; v.we_pc = wpc; v.we_npc = wnpc; v.we_exec = wex;
    v.bp_pc = bp; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic we, input logic [AB-1:0] wpc,
                       input logic [AB-1:0] wnpc, input logic wex, input logic [AB-1:0] bp);
    @(negedge clk);
    i_flush_pipeline = fl; i_we = we; i_we_pc = wpc; i_we_npc = wnpc;
    i_we_exec = wex; i_bp_pc = bp;
  endtask

  task automatic check_slot1(input string name, input logic [AB-1:0] bp, input logic [AB-1:0] exp);
    drive(1'b0, 1'b0, '0, '0, 1'b0, bp);
    #1;
    check(name, W'(o_bp_npc[AB +: AB]), W'(exp));
  endtask

  // Reference: valid entries kept as an MRU-first queue.
  function automatic logic [W-1:0] model_lookup(input logic [AB-1:0] bp);
    logic [D*AB-1:0] c;
    logic [D-1:0]    ex;
    logic [AB-1:0]   s;
    c = '0; ex = '0; s = bp;
    c[0 +: AB] = bp;
    for (int n = 1; n < D; n++) begin
      logic [AB-1:0] nx;
      nx = s + 64'd4;
      for (int j = 0; j < mq.size(); j++) begin
        if (mq[j].pc == s && (!CONF || mq[j].cnt >= 2)) begin
          nx = mq[j].npc; ex[n] = mq[j].ex;
          break;
        end
      end
      c[n*AB +: AB] = nx;
      s = nx;
    end
    return {c, ex};
  endfunction

  task automatic model_write(input logic [AB-1:0] pc, input logic [AB-1:0] npc, input logic ex);
    int idx;
    ent_t e;
    idx = -1;
    for (int j = 0; j < mq.size(); j++) if (mq[j].pc == pc) begin idx = j; break; end
    if (idx < 0) begin
      e.pc = pc; e.npc = npc; e.ex = ex; e.cnt = 2;
      mq.push_front(e);
      if (mq.size() > N) void'(mq.pop_back());
      return;
    end
    e = mq[idx];
    if (e.ex && !ex) return;
    if (e.npc == npc) begin
      e.cnt = (e.cnt >= 3) ? 3 : e.cnt + 1;
      e.ex  = e.ex | ex;
    end else if (CONF && ex && e.cnt == 3) begin
      e.cnt = 2; e.ex = 1'b1;
    end else begin
      e.npc = npc; e.cnt = 2; e.ex = ex;
    end
    mq.delete(idx);
    mq.push_front(e);
  endtask

  initial begin
    logic [W-1:0] e9;
    logic [AB-1:0] fpc;
    logic [AB-1:0] fnpc;

    e9 = CONF ? chain(64'h100, 64'h200, 64'h204, 64'h208, 4'b0010)
              : chain(64'h100, 64'h400, 64'h404, 64'h408, 4'b0010);
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h1000, chain(64'h1000, 64'h1004, 64'h1008, 64'h100C, 4'b0000)));
    vecs.push_back(mk(0, 1, 64'h1004, 64'h2000, 0, 64'h1000, chain(64'h1000, 64'h1004, 64'h1008, 64'h100C, 4'b0000)));
    vecs.push_back(mk(0, 1, 64'h2000, 64'h1000, 1, 64'h1000, chain(64'h1000, 64'h1004, 64'h2000, 64'h2004, 4'b0000)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h1000, chain(64'h1000, 64'h1004, 64'h2000, 64'h1000, 4'b1000)));
    vecs.push_back(mk(0, 1, 64'h100, 64'h200, 1, 64'h100, chain(64'h100, 64'h104, 64'h108, 64'h10C, 4'b0000)));
    vecs.push_back(mk(0, 1, 64'h100, 64'h300, 0, 64'h100, chain(64'h100, 64'h200, 64'h204, 64'h208, 4'b0010)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h100, chain(64'h100, 64'h200, 64'h204, 64'h208, 4'b0010)));
    vecs.push_back(mk(0, 1, 64'h100, 64'h200, 1, 64'h100, chain(64'h100, 64'h200, 64'h204, 64'h208, 4'b0010)));
    vecs.push_back(mk(0, 1, 64'h100, 64'h400, 1, 64'h100, chain(64'h100, 64'h200, 64'h204, 64'h208, 4'b0010)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h100, e9));
    vecs.push_back(mk(0, 1, 64'h100, 64'h400, 1, 64'h100, e9));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h100, chain(64'h100, 64'h400, 64'h404, 64'h408, 4'b0010)));
    vecs.push_back(mk(1, 1, 64'h500, 64'h600, 1, 64'h1000, chain(64'h1000, 64'h1004, 64'h2000, 64'h1000, 4'b1000)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h1000, chain(64'h1000, 64'h1004, 64'h1008, 64'h100C, 4'b0000)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h500, chain(64'h500, 64'h504, 64'h508, 64'h50C, 4'b0000)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC,
                      chain(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8, 4'b0000)));
    vecs.push_back(mk(0, 1, 64'h700, 64'h800, 0, 64'h700, chain(64'h700, 64'h704, 64'h708, 64'h70C, 4'b0000)));
    vecs.push_back(mk(0, 1, 64'h700, 64'h900, 0, 64'h700, chain(64'h700, 64'h800, 64'h804, 64'h808, 4'b0000)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 64'h700, chain(64'h700, 64'h900, 64'h904, 64'h908, 4'b0000)));

    // Clock/reset
    i_nrst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_nrst = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].flush, vecs[v].we, vecs[v].we_pc, vecs[v].we_npc, vecs[v].we_exec, vecs[v].bp_pc);
      #1;
      check($sformatf("vec%0d", v), {o_bp_npc, o_bp_exec}, vecs[v].exp);
    end

    // MRU eviction: fill N+1, re-hit oldest survivor, add one more.
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i <= N; i++) begin
      fpc = 64'h10000 + 64'(16*i); fnpc = 64'h20000 + 64'(16*i);
      drive(1'b0, 1'b1, fpc, fnpc, 1'b0, '0);
    end
    drive(1'b0, 1'b1, 64'h10010, 64'h20010, 1'b0, '0);
    fpc = 64'h10000 + 64'(16*(N+1)); fnpc = 64'h20000 + 64'(16*(N+1));
    drive(1'b0, 1'b1, fpc, fnpc, 1'b0, '0);
    check_slot1("evict_first", 64'h10000, 64'h10004);
    check_slot1("evict_lru", 64'h10020, 64'h10024);
    check_slot1("rehit_kept", 64'h10010, 64'h20010);
    check_slot1("next_kept", 64'h10030, 64'h20030);
    check_slot1("newest_kept", fpc, fnpc);

    // Reset asserted while a write is pending.
    drive(1'b0, 1'b1, 64'h40, 64'h80, 1'b1, 64'h40);
    #2 i_nrst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_we = 1'b0;
    i_nrst = 1'b1;
    #1;
    check("reset_mid_update", {o_bp_npc, o_bp_exec}, chain(64'h40, 64'h44, 64'h48, 64'h4C, 4'b0000));
    check_slot1("reset_clears", 64'h10010, 64'h10014);
    mq.delete();

    // Randomized traffic against the reference queue.
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
            64'h40 + 64'(4*$urandom_range(0, 15)), 64'h40 + 64'(4*$urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, 64'h40 + 64'(4*$urandom_range(0, 15)));
      #1;
      exp_q.push_back(model_lookup(i_bp_pc));
      check("rand_lookup", {o_bp_npc, o_bp_exec}, exp_q.pop_front());
      if (i_flush_pipeline) mq.delete();
      else if (i_we) model_write(i_we_pc, i_we_npc, i_we_exec);
    end

    @(negedge clk);
    i_we = 1'b0;
    i_flush_pipeline = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_btb_multi.md
# bp_btb_multi

Parametrised branch target buffer for the River fetch path: a small fully-associative, MRU-ordered table of (pc → npc) pairs with exec-over-predecode priority, generalised to a configurable table depth, address width and prediction-chain length. Each cycle it produces a chain of PREDICT_DEPTH predicted fetch addresses starting from the current fetch pc. Optionally it adds 2-bit confidence hysteresis so that a single exec mispredict does not evict a good target. It sits between the branch predictor front-end (lookup) and the predecoder/executor (update).

## Interface
- BTB_SIZE, 8, number of table entries (≥1)
- ABITS, RISCV_ARCH, address width of pc/npc
- PREDICT_DEPTH, 4, number of chained predictions per cycle (≥1)

- i_clk  in  1  clock, all state on rising edge
- i_nrst  in  1  reset, asynchronous, active-low
- i_flush_pipeline  in  1  invalidate whole table
- i_we  in  1  update request
- i_we_pc  in  ABITS  branch instruction address
- i_we_npc  in  ABITS  resolved/decoded target
- i_we_exec  in  1  1=update from executor, 0=from predecoder
- i_bp_pc  in  ABITS  current fetch address
- o_bp_npc  out  PREDICT_DEPTH*ABITS  predicted address chain, slot n at bits [n*ABITS +: ABITS]
- o_bp_exec  out  PREDICT_DEPTH  slot n came from an exec-written entry

## Operation
- Entry fields: valid, pc, npc, exec, cnt[1:0]. Index 0 = MRU. Distinct valid entries never share a pc.
- Lookup (combinational): slot0 = i_bp_pc, o_bp_exec[0]=0. For n≥1, search slot n-1 among valid entries. On a usable hit, slot n = entry.npc and o_bp_exec[n] = entry.exec. Otherwise slot n = slot n-1 + 4, modulo 2^ABITS, and o_bp_exec[n]=0. A hit is usable when cnt≥2 (any hit if confidence disabled). If multiple entries match, the lowest index wins.
- Update when i_we=1 and i_flush_pipeline=0:
  - Hit, entry.exec=1, i_we_exec=0: no change at all, including no reordering.
  - Hit, npc equal: cnt=min(cnt+1,3); exec |= i_we_exec; move to index 0.
  - Hit, npc differs, exec write, cnt=3: cnt=2, keep npc, exec=1; move to index 0.
  - Hit, npc differs, otherwise: npc=i_we_npc, cnt=2, exec=i_we_exec; move to index 0.
  - Reordering: entries 0..k-1 shift to 1..k, where k is the hit index.
  - Miss: new entry at index 0 with valid=1 and cnt=2. Every entry shifts down by one; entry BTB_SIZE-1 is discarded.
- Flush: all valid=0, other fields unchanged. Flush has priority over a same-cycle i_we.

## Timing
- Lookup latency 0 cycles; purely combinational from i_bp_pc and table state.
- Update takes effect on the next rising edge. A lookup in the same cycle sees the pre-update table.
- Reset (async assert): every entry valid=0, pc=0, npc=0, exec=0, cnt=0.
- Outputs after reset: slot n = i_bp_pc+4n, o_bp_exec=0.
- Reset mid-update discards the update.
- Wrap-around: i_bp_pc = 2^ABITS-4 gives slot1 = 0 on a miss.
- BTB_SIZE=1: a miss always replaces the sole entry.
- PREDICT_DEPTH=1: o_bp_npc = i_bp_pc only.

## Configuration
- BTB_CONFIDENCE_EN defined: cnt stored, hysteresis rules as above, hits usable only with cnt≥2.
- Not defined: no cnt storage.
  - Every valid hit is usable.
  - Any permitted write with a differing npc overwrites npc and exec.
  - The exec-cnt=3 keep rule does not exist.
  - Priority and MRU ordering are unchanged.

## Test plan
- Reset, i_bp_pc=0x1000, PREDICT_DEPTH=4 -> o_bp_npc slots 0x1000/0x1004/0x1008/0x100C, o_bp_exec=0.
- Predec write 0x1004→0x2000, then exec write 0x2000→0x1000; i_bp_pc=0x1000 -> slots 0x1000/0x1004/0x2000/0x1000, o_bp_exec=4'b1000.
- Exec write 0x100→0x200, then predec write 0x100→0x300 -> lookup 0x100 still predicts 0x200.
- Confidence:
  - Exec 0x100→0x200 twice gives cnt=3.
  - Exec 0x100→0x400 -> still predicts 0x200.
  - A second 0x400 exec write -> predicts 0x400.
  - Without the macro, the first 0x400 write already predicts 0x400.
- Fill BTB_SIZE+1 distinct pcs; re-hit the oldest retained entry, then write one more new pc -> first-written pc misses, re-hit entry survives.
- Same cycle i_we and i_flush_pipeline=1 -> every lookup misses next cycle. i_bp_pc=0xFFFF_FFFF_FFFF_FFFC (ABITS=64) -> slot1=0.
